// File: rtl/darkbusmst_if.sv
// Device bus between the bus master (prod) and a responder (cons).
// DATA is one resolved tri-state net; each side supplies a value and an output enable.
interface darkbusmst_if;
  logic        en;
  logic        re;
  logic        we;
  logic [31:0] addr;
  logic        rack;
  logic        wack;
  logic [31:0] mst_data;
  logic        mst_oe;
  logic [31:0] sub_data;
  logic        sub_oe;
  wire  [31:0] data;

  // With neither side enabled the bus floats.
  assign data = mst_oe ? mst_data : (sub_oe ? sub_data : 32'hzzzz_zzzz);

  modport prod (
    output en, re, we, addr, mst_data, mst_oe,
    input  data, rack, wack
  );

  modport cons (
    input  en, re, we, addr, data,
    output rack, wack, sub_data, sub_oe
  );
endinterface

// File: rtl/darkbusmst.sv
// Single-outstanding bus master: turns core read/write requests into device bus
// cycles, with a wait-cycle timeout and a misalignment error.
module darkbusmst #(
  parameter int TIMEOUT = 16
) (
  input  logic        xclk,
  input  logic        xres,
  input  logic        req,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_rdy,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  darkbusmst_if.prod  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  wait_cnt;
  logic        last_wait;

  assign last_wait = (wait_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge xclk) begin
    if (xres) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wait_cnt  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            wait_cnt <= '0;
            if (req_addr[1:0] != 2'b00) begin
              state     <= RESP;
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
            end else if (req_we) begin
              state <= WR_WAIT;
            end else begin
              state <= RD_WAIT;
            end
          end
        end
        // An ack on the final wait cycle still counts as success.
        RD_WAIT: begin
          if (bus.rack) begin
            state     <= RESP;
            rsp_rdata <= bus.data;
            rsp_err   <= 1'b0;
          end else if (last_wait) begin
            state     <= RESP;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WR_WAIT: begin
          if (bus.wack) begin
            state     <= RESP;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end else if (last_wait) begin
            state     <= RESP;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          if (rsp_rdy) begin
            state     <= IDLE;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus and handshake outputs decode straight from the state register.
  assign req_rdy      = (state == IDLE) && !xres;
  assign rsp_vld      = (state == RESP);
  assign bus.en       = (state == RD_WAIT) || (state == WR_WAIT);
  assign bus.re       = (state == RD_WAIT);
  assign bus.we       = (state == WR_WAIT);
  assign bus.addr     = bus.en ? addr_q : 32'h0;
  assign bus.mst_oe   = (state == WR_WAIT);
  assign bus.mst_data = (state == WR_WAIT) ? wdata_q : 32'h0;

endmodule

// File: tb/tb_darkbusmst.sv
// Scoreboard bench for darkbusmst: directed scenarios plus randomized traffic
// against a delay-programmable responder and a word-level memory model.
module tb_darkbusmst;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          en_cycles;
  } exp_t;

  logic        xclk = 1'b0;
  logic        xres;
  logic        req;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_rdy;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  darkbusmst_if bus ();

  darkbusmst #(.TIMEOUT(TIMEOUT)) dut (
    .xclk      (xclk),
    .xres      (xres),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rdy   (req_rdy),
    .rsp_vld   (rsp_vld),
    .rsp_rdy   (rsp_rdy),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .bus       (bus)
  );

  always #5 xclk = ~xclk;

  int          n_checks = 0;
  int          n_fails = 0;
  int          n_pushed = 0;
  int          n_popped = 0;
  exp_t        sb[$];
  logic [31:0] model_mem[16];
  logic [31:0] dev_mem[16];
  logic        dev_loaded = 1'b0;
  logic        cur_we = 1'b0;
  logic [31:0] cur_addr = 32'h0;
  logic [31:0] cur_wdata = 32'h0;
  int          cur_delay = 0;
  logic        spur_en = 1'b0;
  logic        force_rack = 1'b0;
  logic        rdy_random = 1'b0;
  logic        rdy_fixed = 1'b1;
  int          en_cnt = 0;

  function automatic logic [31:0] init_word(input int i);
    return (i == 2) ? 32'hDEAD_BEEF : (32'hA500_0000 | (32'(i) * 32'h0001_0101));
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Responder: acks cur_delay cycles after EN first rises (0 = never answers).
  always @(posedge xclk) begin
    if (xres && !dev_loaded) begin
      for (int i = 0; i < 16; i++) dev_mem[i] <= init_word(i);
      dev_loaded <= 1'b1;
    end
    en_cnt       <= bus.en ? en_cnt + 1 : 0;
    bus.rack     <= 1'b0;
    bus.wack     <= 1'b0;
    bus.sub_oe   <= 1'b0;
    bus.sub_data <= 32'h0;
    if (bus.en && (en_cnt + 1 == cur_delay)) begin
      if (bus.re) begin
        bus.rack     <= 1'b1;
        bus.sub_oe   <= 1'b1;
        bus.sub_data <= dev_mem[bus.addr[5:2]];
      end else if (bus.we) begin
        bus.wack <= 1'b1;
        dev_mem[bus.addr[5:2]] <= bus.data;
      end
    end
    if (spur_en && bus.en && bus.re) bus.wack <= 1'b1;
    if (spur_en && bus.en && bus.we) bus.rack <= 1'b1;
    if (spur_en && rsp_vld) begin
      bus.rack <= 1'b1;
      bus.wack <= 1'b1;
    end
    if (force_rack) bus.rack <= 1'b1;
  end

  initial begin
    rsp_rdy = 1'b0;
    forever begin
      @(posedge xclk);
      #2;
      rsp_rdy = rdy_random ? ($urandom_range(0, 2) != 0) : rdy_fixed;
    end
  end

  // Monitor: bus protocol every cycle, scoreboard pop on each new response.
  int          en_run = 0;
  logic        in_resp = 1'b0;
  logic [31:0] held_rdata;
  logic        held_err;
  exp_t        mon_e;

  always @(negedge xclk) begin
    if (xres) begin
      en_run  = 0;
      in_resp = 1'b0;
    end else begin
      if (bus.en) begin
        en_run++;
        check_output("bus_addr", bus.addr, cur_addr);
        check_output("bus_dir", {30'h0, bus.re, bus.we}, cur_we ? 32'h1 : 32'h2);
        if (bus.we) begin
          check_output("wr_data", bus.data, cur_wdata);
          check_output("wr_oe", {31'h0, bus.mst_oe}, 32'h1);
        end
      end else begin
        check_output("idle_addr", bus.addr, 32'h0);
        check_output("idle_ctl", {29'h0, bus.re, bus.we, bus.mst_oe}, 32'h0);
      end
      if (rsp_vld) begin
        if (!in_resp) begin
          if (sb.size() == 0) begin
            check_output("unexpected_rsp", 32'h1, 32'h0);
          end else begin
            mon_e = sb.pop_front();
            n_popped++;
            check_output("rsp_rdata", rsp_rdata, mon_e.rdata);
            check_output("rsp_err", {31'h0, rsp_err}, {31'h0, mon_e.err});
            check_output("en_cycles", 32'(en_run), 32'(mon_e.en_cycles));
          end
          held_rdata = rsp_rdata;
          held_err   = rsp_err;
          en_run     = 0;
          in_resp    = 1'b1;
        end else begin
          check_output("hold_rdata", rsp_rdata, held_rdata);
          check_output("hold_err", {31'h0, rsp_err}, {31'h0, held_err});
        end
      end else begin
        in_resp = 1'b0;
      end
    end
  end

  // Issues one request; the expected response comes from word-level rules.
  task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input int delay, input bit expect_rsp);
    exp_t e;
    int   waited = 0;
    while (!req_rdy && waited < 300) begin
      @(posedge xclk);
      #1;
      waited++;
    end
    if (!req_rdy) begin
      check_output("req_rdy_wait", 32'h0, 32'h1);
      return;
    end
    cur_we    = we;
    cur_addr  = addr;
    cur_wdata = wdata;
    cur_delay = delay;
    if (addr[1:0] != 2'b00) begin
      e = '{32'h0, 1'b1, 0};
    end else if (delay == 0 || delay > TIMEOUT) begin
      e = '{32'h0, 1'b1, TIMEOUT};
    end else begin
      if (we && expect_rsp) model_mem[addr[5:2]] = wdata;
      if (delay == TIMEOUT) e = '{32'h0, 1'b1, TIMEOUT};
      else e = '{we ? 32'h0 : model_mem[addr[5:2]], 1'b0, delay + 1};
    end
    if (expect_rsp) begin
      sb.push_back(e);
      n_pushed++;
    end
    req       = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge xclk);
    #1;
    req       = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(req_rdy && sb.size() == 0) && n < 500) begin
      @(posedge xclk);
      #1;
      n++;
    end
    if (!(req_rdy && sb.size() == 0)) check_output("idle_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    logic       r_we;
    logic [1:0] r_low;
    int         r_idx;
    int         r_sel;
    int         r_d;

    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic       r_we;
    logic [1:0] r_low;
    int         r_idx;
    int         r_sel;
    int         r_d;

    xres = 1'b1;
    req = 1'b0;
    req_we = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    for (int i = 0; i < 16; i++) model_mem[i] = init_word(i);

    // Reset state, including a request presented during reset.
    repeat (2) begin @(posedge xclk); #1; end
    req = 1'b1;
    req_addr = 32'h0000_0008;
    @(posedge xclk);
    #1;
    check_output("rst_req_rdy", {31'h0, req_rdy}, 32'h0);
    check_output("rst_rsp_vld", {31'h0, rsp_vld}, 32'h0);
    check_output("rst_rdata", rsp_rdata, 32'h0);
    check_output("rst_err", {31'h0, rsp_err}, 32'h0);
    check_output("rst_bus", {28'h0, bus.en, bus.re, bus.we, bus.mst_oe}, 32'h0);
    req = 1'b0;
    xres = 1'b0;
    #1;
    check_output("rdy_after_rst", {31'h0, req_rdy}, 32'h1);

    // Registered-ack ROM read of word 2: EN in A+1, response in A+3.
    apply_stimulus(1'b0, 32'h0000_0008, 32'h0, 1, 1'b1);
    check_output("rd_en_a1", {30'h0, bus.en, bus.re}, 32'h3);
    @(posedge xclk); #1;
    check_output("rd_vld_a2", {31'h0, rsp_vld}, 32'h0);
    @(posedge xclk); #1;
    check_output("rd_vld_a3", {31'h0, rsp_vld}, 32'h1);
    check_output("rd_data_a3", rsp_rdata, 32'hDEAD_BEEF);
    wait_idle();

    // Write with ack 3 cycles after EN, then read it back.
    apply_stimulus(1'b1, 32'h0000_0010, 32'h1234_5678, 3, 1'b1);
    wait_idle();
    check_output("wr_oe_after", {31'h0, bus.mst_oe}, 32'h0);
    apply_stimulus(1'b0, 32'h0000_0010, 32'h0, 2, 1'b1);
    wait_idle();

    // No responder: exactly TIMEOUT cycles of EN, then an error.
    apply_stimulus(1'b0, 32'h0000_0020, 32'h0, 0, 1'b1);
    wait_idle();

    // Misaligned read with RSP_RDY withheld for 4 cycles.
    rdy_fixed = 1'b0;
    apply_stimulus(1'b0, 32'h0000_0006, 32'h0, 1, 1'b1);
    check_output("mis_vld_a1", {30'h0, rsp_vld, rsp_err}, 32'h3);
    check_output("mis_no_en", {31'h0, bus.en}, 32'h0);
    repeat (4) begin @(posedge xclk); #1; end
    check_output("mis_still_vld", {31'h0, rsp_vld}, 32'h1);
    rdy_fixed = 1'b1;
    @(posedge xclk); #1;
    check_output("mis_back_idle", {30'h0, req_rdy, rsp_vld}, 32'h2);

    // Spurious RACK while idle, then a read with spurious WACKs.
    force_rack = 1'b1;
    repeat (2) begin @(posedge xclk); #1; end
    check_output("spur_idle", {29'h0, req_rdy, rsp_vld, bus.en}, 32'h4);
    force_rack = 1'b0;
    repeat (2) begin @(posedge xclk); #1; end
    spur_en = 1'b1;
    apply_stimulus(1'b0, 32'h0000_000C, 32'h0, 4, 1'b1);
    wait_idle();
    spur_en = 1'b0;

    // Reset in the second read wait cycle while RACK is returned.
    apply_stimulus(1'b0, 32'h0000_0004, 32'h0, 1, 1'b0);
    @(posedge xclk); #1;
    xres = 1'b1;
    req = 1'b1;
    req_we = 1'b0;
    req_addr = 32'h0000_0004;
    check_output("mid_rst_rdy", {31'h0, req_rdy}, 32'h0);
    @(posedge xclk); #1;
    check_output("mid_rst_out", {30'h0, bus.en, rsp_vld}, 32'h0);
    check_output("mid_rst_rdata", rsp_rdata, 32'h0);
    @(posedge xclk); #1;
    check_output("mid_rst_hold", {30'h0, bus.en, rsp_vld}, 32'h0);
    req = 1'b0;
    xres = 1'b0;
    #1;
    check_output("mid_rst_rdy_after", {31'h0, req_rdy}, 32'h1);

    // Randomized traffic with a randomly stalling core.
    rdy_random = 1'b1;
    for (int t = 0; t < 60; t++) begin
      r_we  = 1'($urandom);
      r_idx = $urandom_range(0, 15);
      r_low = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r_sel = $urandom_range(0, 9);
      if (r_sel == 0) r_d = 0;
      else if (r_sel == 1) r_d = TIMEOUT;
      else if (r_sel == 2) r_d = TIMEOUT - 1;
      else r_d = $urandom_range(1, 5);
      spur_en = 1'($urandom);
      apply_stimulus(r_we, {26'h0, 4'(r_idx), r_low}, $urandom, r_d, 1'b1);
      repeat ($urandom_range(0, 2)) begin @(posedge xclk); #1; end
    end
    wait_idle();
    check_output("all_popped", 32'(n_popped), 32'(n_pushed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/darkbusmst.md
DARKBUSMST -- requirements
Module: darkbusmst

Interface
REQ-001 Parameter TIMEOUT, default 16, bus wait-cycle limit before a transaction is aborted with error; legal range 2..255.
REQ-002 XCLK  input  1  single clock; all state changes on posedge XCLK.
REQ-003 XRES  input  1  reset; synchronous, active-high.
REQ-004 REQ  input  1  core request valid.
REQ-005 REQ_WE  input  1  1 = write, 0 = read; sampled with REQ.
REQ-006 REQ_ADDR  input  32  byte address; sampled with REQ.
REQ-007 REQ_WDATA  input  32  write data; sampled with REQ.
REQ-008 REQ_RDY  output  1  block can accept a request this cycle.
REQ-009 RSP_VLD  output  1  response valid.
REQ-010 RSP_RDY  input  1  core accepts response.
REQ-011 RSP_RDATA  output  32  read data; 0 for writes and errors.
REQ-012 RSP_ERR  output  1  transaction failed (timeout or misalignment).
REQ-013 BUS  device_bus.prod  --  initiator end of device_bus: drives EN, RE, WE, ADDR[31:0]; DATA[31:0] bidirectional tri-state; receives RACK, WACK.

Function
REQ-014 States: IDLE, RD_WAIT, WR_WAIT, RESP; the state register updates only on posedge XCLK.
REQ-015 REQ_RDY = 1 only in IDLE; a request is accepted on an edge where REQ & REQ_RDY = 1, and REQ_ADDR, REQ_WE and REQ_WDATA are registered on that edge.
REQ-016 Accepted request with REQ_ADDR[1:0] != 0: go to RESP with RSP_ERR=1 and RSP_RDATA=0; no bus cycle is issued (EN stays 0).
REQ-017 Aligned accepted read -> RD_WAIT; aligned accepted write -> WR_WAIT.
REQ-018 In RD_WAIT: EN=1, RE=1, WE=0, ADDR = registered address; the block drives DATA as Z.
REQ-019 In WR_WAIT: EN=1, WE=1, RE=0, ADDR = registered address; DATA = registered write data.
REQ-020 In IDLE and RESP: EN=RE=WE=0, ADDR=0, DATA=Z.
REQ-021 The block never drives DATA outside WR_WAIT.
REQ-022 RD_WAIT, edge with RACK=1: capture BUS.DATA into RSP_RDATA, RSP_ERR=0, go to RESP.
REQ-023 WR_WAIT, edge with WACK=1: RSP_RDATA=0, RSP_ERR=0, go to RESP.
REQ-024 Only the matching ack counts: WACK in RD_WAIT, RACK in WR_WAIT, and any ack in IDLE or RESP are ignored.
REQ-025 8-bit wait counter: cleared on entry to RD_WAIT/WR_WAIT, incremented each wait cycle without a matching ack.
REQ-026 On the TIMEOUT-th wait cycle without an ack: go to RESP with RSP_ERR=1 and RSP_RDATA=0.
REQ-027 If the ack and the timeout occur on the same edge, the ack wins (success).
REQ-028 RSP_VLD = 1 exactly in RESP; RSP_RDATA and RSP_ERR are held stable while in RESP.
REQ-029 Leave RESP for IDLE on the edge where RSP_RDY=1; RSP_RDY outside RESP is ignored.
REQ-030 Read latency with a responder that registers its ack on the first EN&RE sample: request accepted in cycle A, EN high in A+1, RACK high in A+2, RSP_VLD high in A+3.
REQ-031 Throughput: at most one outstanding transaction; a new request is accepted no earlier than the cycle after RESP exits.

Reset
REQ-032 An edge with XRES=1 forces IDLE from any state, including mid-transaction, and clears the counter and the captured address/data.
REQ-033 Outputs from the reset edge onward: REQ_RDY=0 while XRES=1, then 1; RSP_VLD=0, RSP_RDATA=0, RSP_ERR=0, EN=RE=WE=0, ADDR=0, DATA=Z.
REQ-034 A request presented while XRES=1 is not accepted; an ack arriving after a reset-aborted transaction is ignored.

Verification
REQ-035 Read 0x0000_0008 against a registered-ack ROM model holding 0xDEAD_BEEF at word 2, RSP_RDY=1 -> EN/RE high in A+1, RSP_VLD in A+3, RSP_RDATA=0xDEAD_BEEF, RSP_ERR=0.
REQ-036 Write 0x0000_0010 with data 0x1234_5678, WACK returned 3 cycles after EN -> DATA=0x1234_5678 throughout WR_WAIT, then RSP_VLD=1, RSP_ERR=0, RSP_RDATA=0, DATA=Z afterwards.
REQ-037 Read with no responder, TIMEOUT=16 -> EN high for exactly 16 cycles, then RSP_VLD=1, RSP_ERR=1, RSP_RDATA=0.
REQ-038 Read of address 0x0000_0006 -> no EN pulse, RSP_VLD=1 and RSP_ERR=1 in A+1; RSP_RDY held 0 for 4 cycles -> RSP_VLD and outputs stable throughout, IDLE on the RSP_RDY edge.
REQ-039 XRES=1 in the second RD_WAIT cycle while the model returns RACK=1 -> next cycle IDLE, EN=0, RSP_VLD=0, RSP_RDATA=0; REQ_RDY=1 once XRES=0.
REQ-040 Spurious WACK during RD_WAIT and RACK during IDLE -> no state change; the read completes only on RACK.
